// File: rtl/painterengine_gpu_fifo_reader.sv
// Burst drain engine: pops a fixed number of words from the GPU FIFO read side and
// presents them on a valid/ready stream. Optional last flag: PAINTERENGINE_GPU_FIFO_READER_LAST_EN.
module painterengine_gpu_fifo_reader #(
   parameter int unsigned PARAM_DATA_WIDTH   = 32,
   parameter int unsigned PARAM_LENGTH_WIDTH = 16
) (
   input  logic                          i_wire_clock,
   input  logic                          i_wire_reset,
   input  logic                          i_wire_start,
   input  logic [PARAM_LENGTH_WIDTH-1:0] i_wire_length,
   output logic                          o_wire_busy,
   output logic                          o_wire_done,
   output logic                          o_wire_fifo_read,
   input  logic [PARAM_DATA_WIDTH-1:0]   i_wire_fifo_data,
   input  logic [7:0]                    i_wire_fifo_data_count,
   output logic                          o_wire_valid,
   input  logic                          i_wire_ready,
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
   output logic                          o_wire_last,
`endif
   output logic [PARAM_DATA_WIDTH-1:0]   o_wire_data
);

   localparam int unsigned DW = PARAM_DATA_WIDTH;
   localparam int unsigned LW = PARAM_LENGTH_WIDTH;
   localparam int unsigned OW = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e          state_q;
   logic [LW-1:0]   len_q;
   logic [LW-1:0]   read_cnt_q;
   logic [LW-1:0]   sent_cnt_q;
   logic [OW-1:0]   occ_q;
   logic [OW-1:0]   occ_d;
   logic [OW-1:0]   occ_after_pop;
   logic [DW-1:0]   data0_q;
   logic [DW-1:0]   data1_q;
   logic [DW-1:0]   data0_d;
   logic [DW-1:0]   data1_d;
   logic            valid_q;
   logic            busy_q;
   logic            done_q;
   logic            cnt_ok_q;
   logic            rd_prev_q;
   logic            head_ok;
   logic            fifo_read;
   logic            pop;
   logic            read_is_final;
   logic            send_is_final;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
   logic            last0_q;
   logic            last1_q;
   logic            last0_d;
   logic            last1_d;
`endif

   // The FIFO data register trails its pointers by a cycle: a lone word is only
   // trustworthy once it has been present for a full cycle without a pop.
   assign head_ok = (i_wire_fifo_data_count >= 8'd2) ||
                    ((i_wire_fifo_data_count == 8'd1) && cnt_ok_q && !rd_prev_q);

   assign fifo_read = (state_q == ST_FETCH) && head_ok &&
                      (occ_q < OW'(2)) && (read_cnt_q < len_q);

   assign pop           = valid_q && i_wire_ready;
   assign read_is_final = (read_cnt_q + LW'(1)) == len_q;
   assign send_is_final = (sent_cnt_q + LW'(1)) == len_q;
   assign occ_after_pop = occ_q - OW'(pop);

   // Two-entry buffer: entry 0 is the head, a pop shifts entry 1 down.
   always_comb begin
      data0_d = data0_q;
      data1_d = data1_q;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
      last0_d = last0_q;
      last1_d = last1_q;
`endif
      if (pop) begin
         data0_d = data1_q;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
         last0_d = last1_q;
         last1_d = 1'b0;
`endif
      end
      if (fifo_read) begin
         if (occ_after_pop == OW'(0)) begin
            data0_d = i_wire_fifo_data;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
            last0_d = read_is_final;
`endif
         end else begin
            data1_d = i_wire_fifo_data;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
            last1_d = read_is_final;
`endif
         end
      end
      occ_d = occ_after_pop + OW'(fifo_read);
   end

   // Control FSM, counters and buffer registers.
   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         read_cnt_q <= '0;
         sent_cnt_q <= '0;
         occ_q      <= '0;
         data0_q    <= '0;
         data1_q    <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_ok_q   <= 1'b0;
         rd_prev_q  <= 1'b0;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
         last0_q    <= 1'b0;
         last1_q    <= 1'b0;
`endif
      end else begin
         cnt_ok_q  <= (i_wire_fifo_data_count != 8'd0);
         rd_prev_q <= fifo_read;
         occ_q     <= occ_d;
         data0_q   <= data0_d;
         data1_q   <= data1_d;
         valid_q   <= (occ_d != OW'(0));
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
         last0_q   <= last0_d;
         last1_q   <= last1_d;
`endif
         if (fifo_read) begin
            read_cnt_q <= read_cnt_q + LW'(1);
         end
         if (pop) begin
            sent_cnt_q <= sent_cnt_q + LW'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (i_wire_start) begin
                  len_q      <= i_wire_length;
                  read_cnt_q <= '0;
                  sent_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  if (i_wire_length == LW'(0)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (fifo_read && read_is_final) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && send_is_final) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_wire_busy      = busy_q;
   assign o_wire_done      = done_q;
   assign o_wire_fifo_read = fifo_read;
   assign o_wire_valid     = valid_q;
   assign o_wire_data      = data0_q;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
   assign o_wire_last      = last0_q;
`endif

endmodule

// File: tb/tb_painterengine_gpu_fifo_reader.sv
// Bench for painterengine_gpu_fifo_reader: behavioural FIFO with a lagging data register,
// a count-based stream model checked every cycle, and directed plus random bursts.
module tb_painterengine_gpu_fifo_reader;

   localparam int unsigned DW = 32;
   localparam int unsigned LW = 16;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   logic          wr    = 1'b0;
   logic          clr   = 1'b0;
   logic [LW-1:0] len   = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] f_dout = 32'hDEAD_BEEF;
   logic [7:0]    f_cnt  = 8'd0;
   logic          busy, done, frd, valid;
   logic [DW-1:0] data;
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
   logic          last;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   painterengine_gpu_fifo_reader #(
      .PARAM_DATA_WIDTH  (DW),
      .PARAM_LENGTH_WIDTH(LW)
   ) dut (
      .i_wire_clock          (clk),
      .i_wire_reset          (rst),
      .i_wire_start          (start),
      .i_wire_length         (len),
      .o_wire_busy           (busy),
      .o_wire_done           (done),
      .o_wire_fifo_read      (frd),
      .i_wire_fifo_data      (f_dout),
      .i_wire_fifo_data_count(f_cnt),
      .o_wire_valid          (valid),
      .i_wire_ready          (ready),
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
      .o_wire_last           (last),
`endif
      .o_wire_data           (data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO: count and pointers move at the edge, the data register shows the new
   // head only if that word was already stored before the edge.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] hist[$];
   int total_reads = 0;

   always @(posedge clk) begin
      if (clr) begin
         fq.delete();
         hist.delete();
         f_dout <= 32'hDEAD_BEEF;
      end else begin
         if (frd) begin
            if (fq.size() > 0) void'(fq.pop_front());
            total_reads++;
         end
         if (fq.size() > 0) f_dout <= fq[0];
         else               f_dout <= 32'hDEAD_BEEF;
         if (wr) begin
            fq.push_back(wdata);
            hist.push_back(wdata);
         end
      end
      f_cnt <= 8'(fq.size());
   end

   // Stream model: burst progress tracked only as read/handshake counts.
   bit            m_active = 1'b0;
   int            m_len = 0, m_reads = 0, m_hs = 0, occ = 0;
   logic [7:0]    p_cnt = 8'd0;
   bit            p_rd = 1'b0;
   bit            e_hok, e_rd, e_valid, e_done, e_hs;
   logic [DW-1:0] infl[$];
   logic [DW-1:0] slog[$];
   int            n_busy = 0, n_done = 0;
   logic [DW-1:0] last_word = '0;

   always @(negedge clk) begin
      e_hok   = (f_cnt >= 8'd2) || (f_cnt == 8'd1 && p_cnt >= 8'd1 && !p_rd);
      occ     = m_reads - m_hs;
      e_done  = m_active && (m_hs == m_len);
      e_rd    = m_active && (m_reads < m_len) && e_hok && (occ < 2);
      e_valid = (occ > 0);
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(e_done));
      chk("fifo_read", 64'(frd), 64'(e_rd));
      chk("valid", 64'(valid), 64'(e_valid));
      if (e_valid && infl.size() > 0) chk("data", 64'(data), 64'(infl[0]));
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
      chk("last", 64'(last), 64'(e_valid && (m_hs == m_len - 1)));
      if (e_valid && ready && last) last_word = data;
`endif
      if (busy) n_busy++;
      if (done) n_done++;
      e_hs = e_valid && ready;
      if (e_rd) begin
         if (hist.size() > 0) infl.push_back(hist.pop_front());
         m_reads++;
      end
      if (rst) begin
         m_active = 1'b0;
         m_reads  = 0;
         m_hs     = 0;
         infl.delete();
      end else begin
         if (e_hs) begin
            if (infl.size() > 0) slog.push_back(infl.pop_front());
            m_hs++;
         end
         if (e_done) begin
            m_active = 1'b0;
         end else if (!m_active && start) begin
            m_active = 1'b1;
            m_len    = int'(len);
            m_reads  = 0;
            m_hs     = 0;
         end
      end
      p_cnt = f_cnt;
      p_rd  = frd;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wr = 1'b1;
      wdata = d;
      cyc();
      wr = 1'b0;
   endtask

   task automatic go(input int n);
      start = 1'b1;
      len = LW'(n);
      cyc();
      start = 1'b0;
   endtask

   task automatic flush();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      cyc();
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) seen = 1'b1;
         else cyc();
      end
      chk(tag, 64'(seen), 64'd1);
      cyc();
   endtask

   task automatic chk_log(input string tag, input int n, input logic [DW-1:0] base);
      chk(tag, 64'(slog.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < slog.size()) chk(tag, 64'(slog[i]), 64'(base + DW'(i)));
      end
   endtask

   initial begin
      int r0, r1, d0, b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_data", 64'(data), 64'd0);
      chk("rst_read", 64'(frd), 64'd0);

      // Four words at full rate, with a start pulse mid-burst that must be ignored.
      for (int i = 0; i < 8; i++) push(32'h100 + DW'(i));
      cyc(); cyc();
      slog.delete();
      r0 = total_reads;
      d0 = n_done;
      ready = 1'b1;
      go(4);
      start = 1'b1; len = LW'(1); cyc(); start = 1'b0;
      wait_done(40, "t1_timeout");
      chk("t1_reads", 64'(total_reads - r0), 64'd4);
      chk("t1_fifo_count", 64'(f_cnt), 64'd4);
      chk("t1_done_pulses", 64'(n_done - d0), 64'd1);
      chk_log("t1_stream", 4, 32'h100);

      // Zero-length burst.
      r0 = total_reads;
      d0 = n_done;
      b0 = n_busy;
      go(0);
      chk("t2_done_next", 64'(done), 64'd1);
      repeat (4) cyc();
      chk("t2_reads", 64'(total_reads - r0), 64'd0);
      chk("t2_busy_cycles", 64'(n_busy - b0), 64'd1);
      chk("t2_done_pulses", 64'(n_done - d0), 64'd1);

      // Back-pressure: buffer fills with two words and holds its head.
      ready = 1'b0;
      flush();
      for (int i = 0; i < 8; i++) push(32'h100 + DW'(i));
      cyc(); cyc();
      slog.delete();
      r0 = total_reads;
      go(8);
      repeat (5) cyc();
      chk("t3_stall_reads", 64'(total_reads - r0), 64'd2);
      chk("t3_head", 64'(data), 64'h100);
      chk("t3_valid", 64'(valid), 64'd1);
      ready = 1'b1;
      wait_done(60, "t3_timeout");
      chk_log("t3_stream", 8, 32'h100);

      // Starved FIFO: words trickle in three cycles apart.
      flush();
      slog.delete();
      r0 = total_reads;
      go(3);
      cyc(); cyc();
      push(32'hA); cyc(); cyc();
      push(32'hB); cyc(); cyc();
      push(32'hC);
      wait_done(30, "t4_timeout");
      chk("t4_reads", 64'(total_reads - r0), 64'd3);
      chk("t4_n", 64'(slog.size()), 64'd3);
      if (slog.size() == 3) begin
         chk("t4_w0", 64'(slog[0]), 64'hA);
         chk("t4_w1", 64'(slog[1]), 64'hB);
         chk("t4_w2", 64'(slog[2]), 64'hC);
      end

      // Reset two cycles into a burst, then a fresh short burst.
      flush();
      for (int i = 0; i < 10; i++) push(32'h200 + DW'(i));
      cyc(); cyc();
      r0 = total_reads;
      go(8);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_read", 64'(frd), 64'd0);
      chk("t5_valid", 64'(valid), 64'd0);
      chk("t5_data", 64'(data), 64'd0);
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
      chk("t5_last", 64'(last), 64'd0);
`endif
      cyc();
      r1 = total_reads;
      slog.delete();
      go(2);
      wait_done(30, "t5_timeout");
      chk_log("t5_stream", 2, 32'h200 + DW'(r1 - r0));

      // Random ready, random interleaved writes, stray start pulses.
      flush();
      for (int i = 0; i < 4; i++) push(32'h100 + DW'(i));
      cyc(); cyc();
      for (int b = 0; b < 6; b++) begin
         int  n, pushed;
         bit  seen;
         n = (b == 0) ? 4 : $urandom_range(1, 7);
         pushed = (b == 0) ? 4 : 0;
         seen = 1'b0;
         slog.delete();
         go(n);
         for (int i = 0; i < 300 && !seen; i++) begin
            if (done) begin
               seen = 1'b1;
            end else begin
               ready = ($urandom_range(0, 3) != 0);
               wr    = (pushed < n) && ($urandom_range(0, 1) == 1);
               wdata = $urandom;
               if (wr) pushed++;
               start = ($urandom_range(0, 7) == 0);
               len   = LW'($urandom_range(0, 9));
               cyc();
            end
         end
         wr = 1'b0;
         start = 1'b0;
         chk("t6_timeout", 64'(seen), 64'd1);
         cyc();
         chk("t6_words", 64'(slog.size()), 64'(n));
`ifdef PAINTERENGINE_GPU_FIFO_READER_LAST_EN
         if (b == 0) chk("t6_last_word", 64'(last_word), 64'h103);
`endif
         if (b == 0 && slog.size() == 4) chk("t6_final", 64'(slog[3]), 64'h103);
      end

      repeat (3) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
